// File: rtl/q88_requantizer.sv
// Streaming Q8.8 -> int8 requantizer: per-channel scale, round-half-up shift, zero point, saturation.
// Optional saturation counter enabled by defining REQUANT_SAT_CNT_EN.
module q88_requantizer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned SCALE_W    = 16,
  parameter int unsigned SCALE_FRAC = 8,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned NUM_CH     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_last,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
  input  logic [SCALE_W-1:0]        cfg_scale,
  input  logic [OUT_W-1:0]          cfg_zp,
  output logic [15:0]               sat_count
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned PROD_W = DATA_W + SCALE_W + 1;
  localparam int unsigned SUM_W  = PROD_W + 2;
  localparam int unsigned SHIFT  = FRAC_W + SCALE_FRAC;

  localparam logic signed [SUM_W-1:0] BIAS = SUM_W'(2 ** (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] OMAX = SUM_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] OMIN = SUM_W'(-(2 ** (OUT_W - 1)));

  // Per-channel coefficient table
  logic        [SCALE_W-1:0] r_scale [NUM_CH];
  logic signed [OUT_W-1:0]   r_zp    [NUM_CH];
  logic        [CH_W-1:0]    r_ch;

  // Stage 1: accepted sample plus its coefficients
  logic                      r_s1_v;
  logic signed [DATA_W-1:0]  r_s1_data;
  logic                      r_s1_last;
  logic        [SCALE_W-1:0] r_s1_m;
  logic signed [OUT_W-1:0]   r_s1_zp;

  // Stage 2: full-precision product
  logic                      r_s2_v;
  logic signed [PROD_W-1:0]  r_s2_prod;
  logic                      r_s2_last;
  logic signed [OUT_W-1:0]   r_s2_zp;

  // Stage 3: output register
  logic                      r_out_valid;
  logic        [OUT_W-1:0]   r_out_data;
  logic                      r_out_last;

  logic                      w_ld1;
  logic                      w_ld2;
  logic                      w_ld3;
  logic                      w_accept;
  logic signed [PROD_W-1:0]  w_a;
  logic signed [PROD_W-1:0]  w_b;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [SUM_W-1:0]   w_biased;
  logic signed [SUM_W-1:0]   w_sh;
  logic signed [SUM_W-1:0]   w_sum;
  logic                      w_hi;
  logic                      w_lo;
  logic        [OUT_W-1:0]   w_res;

  // A stage advances when it is empty or its successor is taking its contents
  assign w_ld3    = !r_out_valid || out_ready;
  assign w_ld2    = !r_s2_v || w_ld3;
  assign w_ld1    = !r_s1_v || w_ld2;
  assign in_ready = w_ld1;
  assign w_accept = in_valid && w_ld1;

  assign w_a    = PROD_W'(r_s1_data);
  assign w_b    = PROD_W'(signed'({1'b0, r_s1_m}));
  assign w_prod = w_a * w_b;

  // Bias then arithmetic shift gives round-half toward +inf
  assign w_biased = SUM_W'(r_s2_prod) + BIAS;
  assign w_sh     = w_biased >>> SHIFT;
  assign w_sum    = w_sh + SUM_W'(r_s2_zp);
  assign w_hi     = w_sum > OMAX;
  assign w_lo     = w_sum < OMIN;
  assign w_res    = w_hi ? OUT_W'(OMAX) : (w_lo ? OUT_W'(OMIN) : w_sum[OUT_W-1:0]);

  // Coefficient table; a same-cycle read by stage 1 sees the old entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_scale[CH_W'(i)] <= SCALE_W'(2 ** SCALE_FRAC);
        r_zp[CH_W'(i)]    <= '0;
      end
    end else if (cfg_we) begin
      r_scale[cfg_addr] <= cfg_scale;
      r_zp[cfg_addr]    <= cfg_zp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch <= '0;
    end else if (w_accept) begin
      r_ch <= (in_last || (r_ch == CH_W'(NUM_CH - 1))) ? '0 : r_ch + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_last <= 1'b0;
      r_s1_m    <= '0;
      r_s1_zp   <= '0;
    end else if (w_ld1) begin
      r_s1_v    <= in_valid;
      r_s1_data <= in_data;
      r_s1_last <= in_last;
      r_s1_m    <= r_scale[r_ch];
      r_s1_zp   <= r_zp[r_ch];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_v    <= 1'b0;
      r_s2_prod <= '0;
      r_s2_last <= 1'b0;
      r_s2_zp   <= '0;
    end else if (w_ld2) begin
      r_s2_v    <= r_s1_v;
      r_s2_prod <= w_prod;
      r_s2_last <= r_s1_last;
      r_s2_zp   <= r_s1_zp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_ld3) begin
      r_out_valid <= r_s2_v;
      r_out_data  <= w_res;
      r_out_last  <= r_s2_last;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

`ifdef REQUANT_SAT_CNT_EN
  logic        r_out_sat;
  logic [15:0] r_sat_count;

  // Counts clamped beats as they leave; sticks at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_sat   <= 1'b0;
      r_sat_count <= '0;
    end else begin
      if (w_ld3) begin
        r_out_sat <= w_hi || w_lo;
      end
      if (r_out_valid && out_ready && r_out_sat && (r_sat_count != 16'hFFFF)) begin
        r_sat_count <= r_sat_count + 16'd1;
      end
    end
  end

  assign sat_count = r_sat_count;
`else
  assign sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_q88_requantizer.sv
// Self-checking bench for q88_requantizer: real-arithmetic reference model plus directed literal checks.
module tb_q88_requantizer;

  localparam int unsigned NCH = 4;
`ifdef REQUANT_SAT_CNT_EN
  localparam int SATON = 1;
`else
  localparam int SATON = 0;
`endif

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [15:0]            in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_data;
  logic                   out_last;
  logic                   cfg_we;
  logic [$clog2(NCH)-1:0] cfg_addr;
  logic [15:0]            cfg_scale;
  logic [7:0]             cfg_zp;
  logic [15:0]            sat_count;

  q88_requantizer #(.NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale), .cfg_zp(cfg_zp),
    .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       s;
  } exp_t;

  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   mt [NCH];
  int   mz [NCH];
  int   mch;
  int   msat;
  exp_t exp_q [$];
  exp_t e_pop;
  logic [7:0] got_q [$];
  int   got_cyc [$];
  int   acc_cyc [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    else passed++;
  endtask

  // Reference: value = x * M / 2^16 in exact real arithmetic, floor(v + 0.5), add zp, clamp
  function automatic exp_t predict(input logic [15:0] x, input int m, input int zp, input logic last);
    real    r;
    longint v;
    exp_t   e;
    r   = real'($signed(x)) * real'(m) / 65536.0;
    v   = longint'($floor(r + 0.5)) + longint'(zp);
    e.l = last;
    e.s = 1'b0;
    if (v > 127) begin
      v   = 127;
      e.s = 1'b1;
    end else if (v < -128) begin
      v   = -128;
      e.s = 1'b1;
    end
    e.d = 8'(v);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NCH); i++) begin
      mt[i] = 256;
      mz[i] = 0;
    end
    mch  = 0;
    msat = 0;
    exp_q.delete();
  endtask

  // Compare process: inputs are stable at the falling edge, so handshakes seen here happen at the next rising edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      check("sat_count", 64'(sat_count), (SATON != 0) ? 64'(msat) : 64'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q[0].d));
          check("out_last", 64'(out_last), 64'(exp_q[0].l));
          if (out_ready) begin
            e_pop = exp_q.pop_front();
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
            if (e_pop.s && msat < 65535) msat++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(predict(in_data, mt[mch], mz[mch], in_last));
        acc_cyc.push_back(cyc);
        mch = (in_last || mch == int'(NCH) - 1) ? 0 : mch + 1;
      end
      if (cfg_we) begin
        mt[cfg_addr] = int'(cfg_scale);
        mz[cfg_addr] = int'($signed(cfg_zp));
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic l);
    logic r;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (1) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n >= 100) begin
        check("send_accept_timeout", 64'(r), 64'd1);
        break;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cfg(input logic [$clog2(NCH)-1:0] a, input logic [15:0] m, input logic [7:0] z);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_scale = m;
    cfg_zp    = z;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic check_list(input string name, input logic [7:0] ev [$]);
    check({name, "_count"}, 64'(got_q.size()), 64'(ev.size()));
    for (int i = 0; i < ev.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s[%0d]", name, i), 64'(got_q[i]), 64'(ev[i]));
    end
  endtask

  task automatic clear_capture();
    got_q.delete();
    got_cyc.delete();
    acc_cyc.delete();
  endtask

  logic [7:0] ev [$];
  logic       r;
  int         k;
  int         n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_scale = '0; cfg_zp = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_sat_count", 64'(sat_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Default table: unity scale, zero offset, rounding around half
    clear_capture();
    send(16'h0100, 1'b0);
    send(16'h0180, 1'b0);
    send(16'hFE80, 1'b0);
    send(16'h0000, 1'b1);
    idle();
    drain();
    ev = '{8'h01, 8'h02, 8'hFF, 8'h00};
    check_list("defaults", ev);
    if (got_cyc.size() > 0 && acc_cyc.size() > 0)
      check("latency", 64'(got_cyc[0] - acc_cyc[0]), 64'd3);

    // Large scale and positive saturation
    cfg(0, 16'h1000, 8'h00);
    clear_capture();
    send(16'h0100, 1'b1);
    send(16'h7FFF, 1'b1);
    idle();
    drain();
    ev = '{8'h10, 8'h7F};
    check_list("scale16", ev);
    check("sat_after_pos_clamp", 64'(sat_count), 64'(SATON));

    // Negative zero point drives below the int8 floor
    cfg(0, 16'h0100, 8'h80);
    clear_capture();
    send(16'h8000, 1'b1);
    idle();
    drain();
    ev = '{8'h80};
    check_list("neg_clamp", ev);
    check("sat_after_neg_clamp", 64'(sat_count), 64'(2 * SATON));

    // Channel rotation and in_last resync
    cfg(0, 16'h0100, 8'h00);
    cfg(1, 16'h0200, 8'h00);
    cfg(2, 16'h0300, 8'h00);
    cfg(3, 16'h0400, 8'h00);
    clear_capture();
    repeat (6) send(16'h0100, 1'b0);
    send(16'h0100, 1'b1);
    idle();
    drain();
    ev = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03};
    check_list("ch_wrap", ev);
    clear_capture();
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b1);
    repeat (4) send(16'h0100, 1'b0);
    idle();
    drain();
    ev = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
    check_list("ch_resync", ev);

    // Backpressure: three beats held, then full-rate release
    clear_capture();
    out_ready = 1'b0;
    k = 1;
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_data  = 16'(k << 8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      r = in_ready;
      check($sformatf("bp_in_ready_%0d", c), 64'(r), (c < 3) ? 64'd1 : 64'd0);
      @(posedge clk);
      #1;
      if (r) begin
        k++;
        in_data = 16'(k << 8);
      end
    end
    out_ready = 1'b1;
    n = 0;
    while (k <= 8 && n < 50) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        k++;
        in_data = 16'(k << 8);
      end
      n++;
    end
    idle();
    drain();
    ev = '{8'd1, 8'd4, 8'd9, 8'd16, 8'd5, 8'd12, 8'd21, 8'd32};
    check_list("backpressure", ev);
    if (got_cyc.size() == 8) check("release_rate", 64'(got_cyc[7] - got_cyc[0]), 64'd7);

    // Write coinciding with an accepted beat: that beat keeps the old entry
    clear_capture();
    cfg_we = 1'b1; cfg_addr = 0; cfg_scale = 16'h0200; cfg_zp = 8'h00;
    in_valid = 1'b1; in_data = 16'h0100; in_last = 1'b1;
    @(negedge clk);
    r = in_ready;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("cw_accept", 64'(r), 64'd1);
    send(16'h0100, 1'b1);
    idle();
    drain();
    ev = '{8'h01, 8'h02};
    check_list("cfg_same_cycle", ev);

    // Reset with three beats in flight
    cfg(0, 16'h0400, 8'h00);
    out_ready = 1'b0;
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_sat_count", 64'(sat_count), 64'd0);
    @(posedge clk);
    #1;
    cfg(1, 16'h0300, 8'h00);
    clear_capture();
    send(16'h0200, 1'b0);
    send(16'h0200, 1'b1);
    idle();
    drain();
    ev = '{8'h02, 8'h06};
    check_list("after_reset", ev);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/q88_requantizer.md
# q88_requantizer

Streaming requantizer converting signed Q8.8 activation samples, as produced by the hard-swish stage, back into signed int8 tensor values for the next layer's buffers. Applies per-channel scale multiplier, round-half-up shift, zero-point add and int8 saturation, using a 3-stage valid/ready pipeline. The channel index comes from an internal counter that is re-synchronised by `in_last`.

## Interface
- DATA_W, 16, input sample width (signed Q8.8)
- FRAC_W, 8, fractional bits of input
- SCALE_W, 16, unsigned per-channel multiplier width
- SCALE_FRAC, 8, fractional bits of multiplier
- OUT_W, 8, output width (signed)
- NUM_CH, 16, channels per pixel; table depth
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  DATA_W  signed Q8.8 sample
- in_last  in  1  last channel of current pixel
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_data  out  OUT_W  signed int8 result
- out_last  out  1  in_last of this beat, delayed
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(NUM_CH)  channel to write
- cfg_scale  in  SCALE_W  multiplier M
- cfg_zp  in  OUT_W  signed zero point
- sat_count  out  16  saturated-output counter

## Operation
- Reset: every table entry M=1<<SCALE_FRAC (0x0100), zp=0; channel counter 0; all stage valids 0; out_valid=0, out_data=0, out_last=0, sat_count=0.
- Stage 1 (accept): latch in_data, in_last, table[ch].M, table[ch].zp. Counter: if in_last then 0, else if ch==NUM_CH-1 then 0, else ch+1; updates only on accepted beats.
- Stage 2: prod = signed(in_data) * signed({1'b0,M}), width DATA_W+SCALE_W+1.
- Stage 3: sh = (prod + 2^(FRAC_W+SCALE_FRAC-1)) >>> (FRAC_W+SCALE_FRAC); sum = sh + sext(zp); clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Intermediate widths must not overflow before clamp.
- Rounding is half toward +inf (arithmetic shift after bias), e.g. -1.5 -> -1.
- Table write: cfg_we writes entry cfg_addr at clock edge. A beat accepted in the same cycle as a write to its channel uses the old entry; beats accepted later use the new one. Writes allowed any time, including mid-stream.
- Stage k loads when stage k is empty or stage k+1 loads; stage 3 "next" loads when out_ready. in_ready = stage1 empty or stage1 advancing (combinational from out_ready allowed). Bubbles collapse; no beat lost, duplicated or reordered.
- out_data/out_last hold stable while out_valid & !out_ready.

## Timing
- Latency: beat accepted at edge n appears on out_valid after edge n+2 (visible in cycle n+2→n+3 window), given no stall.
- Throughput: 1 beat/cycle with out_ready held high.
- Capacity: 3 beats held when out_ready low; in_ready deasserts when all three stages full and out_ready low.
- Reset asserted mid-stream: at next edge all in-flight beats discarded, outputs return to reset values, table reinitialised.

## Configuration
- REQUANT_SAT_CNT_EN defined: sat_count increments on each output transfer (out_valid & out_ready) whose value was clamped; saturates at 0xFFFF; cleared only by reset.
- Not defined: no counter logic; sat_count drives constant 0.

## Test plan
- Reset defaults (M=0x0100, zp=0): in 0x0100 -> 0x01; 0x0180 -> 0x02; 0xFE80 -> 0xFF (-1); 0x0000 -> 0x00.
- ch0 M=0x1000, zp=0: in 0x0100 -> 0x10; in 0x7FFF -> 0x7F, sat_count 0->1 (macro on), stays 0 (macro off).
- ch0 M=0x0100, zp=0x80: in 0x8000 -> 0x80 (clamped -256), sat_count +1.
- NUM_CH=4, M={0x0100,0x0200,0x0300,0x0400}, six 0x0100 beats without in_last -> 1,2,3,4,1,2; repeat with in_last on beat 2 -> 1,2,1,2,3,4.
- Continuous input, out_ready low 5 cycles: in_ready falls after 3 beats held; after release all beats emerge in order at 1/cycle, none dropped/duplicated.
- rst_n low one cycle with 3 beats in flight -> out_valid 0 next cycle, counter 0, table back to 0x0100/0; next beat 0x0200 on ch0 -> 0x02.
